// File: rtl/design_mux_pkg.sv
// Shared definitions for top_design_mux and its select sequencer.
// State encoding, design indices and default sizes.
package design_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_HOLD    = 2'd3
  } dss_state_e;

  localparam int DSEL_TRZF  = 0;
  localparam int DSEL_TRZF2 = 1;
  localparam int DSEL_DIEGO = 2;

  localparam int DM_NDESIGNS = 8;
  localparam int DM_SEL_W    = 4;

  function automatic int dss_max(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dss_cycle_timer.sv
// Loadable down-counter with zero flag.
// Shared by the QUIESCE and HOLD phases of the sequencer.
module dss_cycle_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/design_select_sequencer.sv
// Quiesce/reset/switch/hold sequencer for top_design_mux select.
// Optional switch counter: define DSS_SWITCH_COUNT_EN.
module design_select_sequencer
  import design_mux_pkg::*;
#(
  parameter int NDESIGNS    = DM_NDESIGNS,
  parameter int SEL_W       = DM_SEL_W,
  parameter int DEFAULT_SEL = DSEL_TRZF,
  parameter int PRE_CYCLES  = 4,
  parameter int POST_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                i_req_valid,
  input  logic [SEL_W-1:0]    i_req_sel,
  output logic                o_req_ready,
  output logic                o_req_err,
  input  logic                i_auto_reset_enb,
  input  logic [NDESIGNS-1:0] i_design_reset,
  output logic [SEL_W-1:0]    o_mux_sel,
  output logic [NDESIGNS-1:0] o_design_rst,
  output logic [NDESIGNS-1:0] o_design_ena,
  output logic                o_io_hold,
  output logic                o_busy,
  output logic [7:0]          o_switch_count
);

  localparam int CNT_W =
    $clog2(dss_max(PRE_CYCLES, POST_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PRE_LD =
    CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LD =
    CNT_W'(POST_CYCLES - 1);
  localparam logic [SEL_W-1:0] DEF_SEL =
    SEL_W'(DEFAULT_SEL);
  localparam logic [NDESIGNS-1:0] ONE =
    NDESIGNS'(1);

  dss_state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic skip_q, skip_d;

  logic [NDESIGNS-1:0] rst_q, rst_d;
  logic [NDESIGNS-1:0] ena_q, ena_d;
  logic [NDESIGNS-1:0] onehot, fsm_rst;
  logic hold_q, hold_d;
  logic busy_q, busy_d;
  logic rdy_q, rdy_d;
  logic err_q, err_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             accept, bad_req;

  assign accept  = i_req_valid & rdy_q;
  assign bad_req = 32'(i_req_sel) >= NDESIGNS;

  dss_cycle_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (POST_CYCLES - 1)
  ) u_timer (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_HOLD;
      sel_q   <= DEF_SEL;
      pend_q  <= DEF_SEL;
      skip_q  <= 1'b0;
      rst_q   <= '1;
      ena_q   <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b1;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
      rst_q   <= rst_d;
      ena_q   <= ena_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pend_d   = pend_q;
    skip_d   = skip_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !bad_req) begin
          pend_d = i_req_sel;
          skip_d = i_auto_reset_enb;
          if (i_auto_reset_enb) begin
            state_d = ST_SWITCH;
          end else begin
            state_d  = ST_QUIESCE;
            tmr_load = 1'b1;
            tmr_val  = PRE_LD;
          end
        end
      end
      ST_QUIESCE: begin
        if (tmr_zero) state_d = ST_SWITCH;
        else          tmr_dec = 1'b1;
      end
      ST_SWITCH: begin
        sel_d  = pend_q;
        skip_d = i_auto_reset_enb;
        if (i_auto_reset_enb) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = POST_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next state so they register in step.
  always_comb begin
    onehot  = ONE << sel_d;
    fsm_rst = '1;
    unique case (state_d)
      ST_IDLE:    fsm_rst = skip_d ? '0 : ~onehot;
      ST_QUIESCE: fsm_rst = '1;
      ST_SWITCH:  fsm_rst = skip_d ? '0 : '1;
      ST_HOLD:    fsm_rst = skip_d ? onehot : '1;
      default:    fsm_rst = '1;
    endcase
    rst_d  = fsm_rst | i_design_reset;
    ena_d  = (state_d == ST_IDLE) ? onehot : '0;
    hold_d = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
    err_d  = accept & bad_req;
  end

`ifdef DSS_SWITCH_COUNT_EN
  logic       req_q, req_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done;

  // Bring-up after reset does not count: req_q is still clear then.
  assign done = req_q && (state_d == ST_IDLE) &&
                (state_q == ST_HOLD || state_q == ST_SWITCH);

  always_comb begin
    req_d = req_q | (accept & ~bad_req);
    cnt_d = cnt_q;
    if (done && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_switch_count = cnt_q;
`else
  assign o_switch_count = 8'd0;
`endif

  assign o_req_ready  = rdy_q;
  assign o_req_err    = err_q;
  assign o_mux_sel    = sel_q;
  assign o_design_rst = rst_q;
  assign o_design_ena = ena_q;
  assign o_io_hold    = hold_q;
  assign o_busy       = busy_q;

endmodule
